msg_schedule_ctrl: RTL
======================

Name: msg_schedule_ctrl

Overview:
Sequencer for the SHA-256 message-schedule expansion built around the SIG0 small-sigma datapath.
- Accepts one 512-bit block as 16 × 32-bit words over a valid/ready stream.
- Emits W[0..63] in order on a second valid/ready stream, feeding the compression round logic.
- Keeps a 16-word circular buffer; instantiates SIG0 (ROTR7^ROTR18^SHR3) and SIG1 (ROTR17^ROTR19^SHR10) once each.

Parameters:
DATA_WIDTH, 32, word width; only 32 is supported (the SHA-256 rotate amounts are fixed)
NUM_ROUNDS, 64, number of schedule words emitted per block

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
S_start_in  input  1  one-cycle pulse that starts a block; honoured only in IDLE
S_W_in  input  32  message word M[t]
S_valid_in  input  1  S_W_in valid
S_ready_out  output  1  word accepted when S_valid_in & S_ready_out
D_W_out  output  32  schedule word W[t]
D_valid_out  output  1  D_W_out valid
D_ready_in  input  1  consumer accepts when D_valid_out & D_ready_in
D_busy_out  output  1  high in any state other than IDLE
D_done_out  output  1  one-cycle pulse when W[63] is consumed

Behaviour:
- Reset (asynchronous): state=IDLE, cnt=0, D_W_out=0, D_valid_out=0, S_ready_out=0, D_done_out=0, D_busy_out=0. Buffer contents need not be cleared.
- adv = !D_valid_out | D_ready_in (the output register is free or is being drained this cycle).
- Internal counter cnt is 7 bits, range 0..64, and holds t of the next word to produce. Buffer index = t mod 16.
- IDLE:
  - S_start_in=1 → LOAD, cnt=0.
  - S_start_in is ignored in all other states.
- LOAD:
  - S_ready_out = adv (combinational).
  - On accept: buf[cnt[3:0]]←S_W_in, D_W_out←S_W_in, D_valid_out←1, cnt++.
  - Accept of M[15] (cnt 15→16) → EXPAND.
- EXPAND, when adv:
  - W = SIG1(buf[(t+14)&15]) + buf[(t+9)&15] + SIG0(buf[(t+1)&15]) + buf[t&15], all additions mod 2^32.
  - buf[t&15]←W, D_W_out←W, D_valid_out←1, cnt++.
  - Producing t=63 → DRAIN.
  - When not adv, hold D_W_out, cnt and buf unchanged.
- DRAIN: on D_valid_out & D_ready_in: D_valid_out←0, D_done_out←1 for one cycle, → IDLE.
- In every state, if the output register is drained and no new word is produced that cycle, D_valid_out←0.
- Latency: 1 cycle from input accept (or EXPAND adv) to D_valid_out. Peak throughput is 1 word/clk; minimum block time is 64 cycles plus 1 cycle for DRAIN.
- D_W_out must not change while D_valid_out=1 and D_ready_in=0.
- Simultaneous drain of W[t-1] and production of W[t] in the same cycle is required for full rate.
- S_ready_out is 0 outside LOAD. S_valid_in outside LOAD is ignored.
- Reset mid-block discards all progress. The next S_start_in begins a fresh block.

Optional Feature:
MSG_SCHED_ROUND_IDX_EN
- Defined: adds output port D_round_out [5:0], registered alongside D_W_out and equal to t of the word currently on D_W_out. Reset value is 0. Holds under backpressure.
- Undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
- Block "abc" padded (M0=0x61626380, M1..M14=0, M15=0x00000018), D_ready_in=1 → W0..W15 echo the inputs; W16=0x61626380, W17=0x000F0000, W18=0x7DA86405; exactly 64 output handshakes; D_done_out pulses once.
- All-ones block (M0..M15=0xFFFFFFFF) → W16=0x203FFFFC, which exercises mod-2^32 wrap.
- "abc" block with D_ready_in low for 5 cycles at t=20 → D_W_out stays at W20 and D_valid_out stays 1; the resulting sequence matches the no-stall run; S_ready_out=0 during LOAD stalls.
- S_start_in pulsed during EXPAND → ignored; cnt and outputs unaffected; D_done_out pulses once.
- rst asserted mid-EXPAND at t=30 → outputs return to reset values asynchronously; a new "abc" block after reset reproduces W16=0x61626380 exactly.
- With MSG_SCHED_ROUND_IDX_EN defined → D_round_out equals t for every accepted word, 0..63, and reads 0 after reset.

Source files
------------

// File: rtl/msg_schedule_ctrl.sv
// SHA-256 message-schedule sequencer: loads 16 words, expands to W[0..63] via a 16-word ring.
// Optional build macro MSG_SCHED_ROUND_IDX_EN adds D_round_out carrying t of the word on D_W_out.
module msg_schedule_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ROUNDS = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  S_start_in,
  input  logic [DATA_WIDTH-1:0] S_W_in,
  input  logic                  S_valid_in,
  output logic                  S_ready_out,
  output logic [DATA_WIDTH-1:0] D_W_out,
  output logic                  D_valid_out,
  input  logic                  D_ready_in,
  output logic                  D_busy_out,
  output logic                  D_done_out
`ifdef MSG_SCHED_ROUND_IDX_EN
  ,
  output logic [5:0]            D_round_out
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DRAIN} state_t;

  localparam logic [6:0] LAST_LOAD  = 7'd15;
  localparam logic [6:0] LAST_ROUND = 7'(NUM_ROUNDS - 1);

  state_t                state_q, state_d;
  logic [6:0]            cnt_q, cnt_d;
  logic                  adv, drain_hs, wr_en, valid_d, done_d;
  logic [DATA_WIDTH-1:0] w_new, w_sel;
  logic [3:0]            t_idx, i1, i9, i14;
  logic [DATA_WIDTH-1:0] wbuf [16];

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // 4-bit index arithmetic wraps mod 16, giving W[t-2], W[t-7], W[t-15], W[t-16] in the ring
  always_comb begin
    t_idx = cnt_q[3:0];
    i1    = t_idx + 4'd1;
    i9    = t_idx + 4'd9;
    i14   = t_idx + 4'd14;
    w_new = sig1(wbuf[i14]) + wbuf[i9] + sig0(wbuf[i1]) + wbuf[t_idx];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    S_ready_out = 1'b0;
    wr_en       = 1'b0;
    done_d      = 1'b0;
    w_sel       = w_new;
    adv         = !D_valid_out | D_ready_in;
    drain_hs    = D_valid_out & D_ready_in;
    case (state_q)
      IDLE: begin
        if (S_start_in) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        S_ready_out = adv;
        if (S_valid_in && adv) begin
          wr_en = 1'b1;
          w_sel = S_W_in;
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == LAST_LOAD) state_d = EXPAND;
        end
      end
      EXPAND: begin
        if (adv) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == LAST_ROUND) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_hs) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // a fresh word always wins over a drain, so full-rate streaming keeps valid high
    if (wr_en)         valid_d = 1'b1;
    else if (drain_hs) valid_d = 1'b0;
    else               valid_d = D_valid_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      D_W_out     <= '0;
      D_valid_out <= 1'b0;
      D_done_out  <= 1'b0;
`ifdef MSG_SCHED_ROUND_IDX_EN
      D_round_out <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      D_valid_out <= valid_d;
      D_done_out  <= done_d;
      if (wr_en) begin
        D_W_out <= w_sel;
`ifdef MSG_SCHED_ROUND_IDX_EN
        D_round_out <= cnt_q[5:0];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) wbuf[t_idx] <= w_sel;
  end

  assign D_busy_out = (state_q != IDLE);

endmodule
